// File: rtl/csa_accum_resolve.sv
// csa_accum_resolve
//   Downstream stage of the WIDTH-bit 4:2 carry-save adder. Folds a packet of
//   redundant (sum, carry) beats into a redundant accumulator using a 4:2
//   compressor. On the last beat, it resolves the pair to binary CHUNK bits
//   per cycle and presents the result through a valid/ready handshake.
//
// Parameters
//   WIDTH  datapath width (matches the upstream adder)
//   CHUNK  bits resolved per cycle; WIDTH must be a multiple of CHUNK
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   beat handshake
//   in_s, in_c          upstream sum / bit-weighted carry vectors
//   in_ovfl, in_last    upstream overflow flag, final beat of packet
//   out_valid/out_ready result handshake
//   out_sum             resolved packet sum, modulo 2^WIDTH
//   out_ovfl            packet overflow (any in_ovfl, or exact sum >= 2^WIDTH)
//   busy                high while resolving or holding a result
module csa_accum_resolve #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_s,
  input  logic [WIDTH-1:0] in_c,
  input  logic             in_ovfl,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovfl,
  output logic             busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % CHUNK) != 0 || WIDTH < 2 || CHUNK < 1) begin : g_bad_params
    $error("csa_accum_resolve: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] acc_s, acc_c;
  logic             ovf;
  logic [IW-1:0]    idx;
  logic             cy;

  // 4:2 compression built from two 3:2 levels. The majority bit shifted out
  // of the top of either level carries weight 2^WIDTH; because every operand
  // is non-negative, losing one means the exact sum has reached 2^WIDTH.
  logic [WIDTH-1:0] m1, s1, c1, m2, s2, c2;
  logic             co1, co2;

  always_comb begin
    m1  = (acc_s & acc_c) | (acc_s & in_s) | (acc_c & in_s);
    s1  = acc_s ^ acc_c ^ in_s;
    c1  = {m1[WIDTH-2:0], 1'b0};
    co1 = m1[WIDTH-1];
    m2  = (s1 & c1) | (s1 & in_c) | (c1 & in_c);
    s2  = s1 ^ c1 ^ in_c;
    c2  = {m2[WIDTH-2:0], 1'b0};
    co2 = m2[WIDTH-1];
  end

  // Chunk-serial carry-propagate add of the selected chunk.
  logic [CHUNK-1:0] ch_s, ch_c;
  logic [CHUNK:0]   ch_sum;
  logic             last_chunk;

  always_comb begin
    ch_s = '0;
    ch_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx == IW'(k)) begin
        ch_s = acc_s[k*CHUNK +: CHUNK];
        ch_c = acc_c[k*CHUNK +: CHUNK];
      end
    end
    ch_sum     = {1'b0, ch_s} + {1'b0, ch_c} + {{CHUNK{1'b0}}, cy};
    last_chunk = (idx == IW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ACCUM:   if (in_valid && in_last) state_nx = RESOLVE;
      RESOLVE: if (last_chunk)          state_nx = OUTPUT;
      OUTPUT:  if (out_ready)           state_nx = ACCUM;
      default:                          state_nx = ACCUM;
    endcase
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == OUTPUT);
  assign busy      = (state != ACCUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_s    <= '0;
      acc_c    <= '0;
      ovf      <= 1'b0;
      idx      <= '0;
      cy       <= 1'b0;
      out_sum  <= '0;
      out_ovfl <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc_s <= s2;
            acc_c <= c2;
            ovf   <= ovf | co1 | co2 | in_ovfl;
            if (in_last) begin
              idx <= '0;
              cy  <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          for (int unsigned k = 0; k < N; k++) begin
            if (idx == IW'(k)) out_sum[k*CHUNK +: CHUNK] <= ch_sum[CHUNK-1:0];
          end
          cy <= ch_sum[CHUNK];
          if (last_chunk) begin
            idx      <= '0;
            ovf      <= ovf | ch_sum[CHUNK];
            out_ovfl <= ovf | ch_sum[CHUNK];
          end else begin
            idx <= idx + 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            acc_s <= '0;
            acc_c <= '0;
            ovf   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum_resolve.sv
// Directed testbench for csa_accum_resolve at default parameters
// (WIDTH=16, CHUNK=4, so the result appears 4 edges after the last beat).
module tb_csa_accum_resolve;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_s = '0;
  logic [15:0] in_c = '0;
  logic        in_ovfl = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_ovfl;
  logic        busy;

  int checks = 0;
  int failures = 0;

  csa_accum_resolve #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_s(in_s), .in_c(in_c), .in_ovfl(in_ovfl), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovfl(out_ovfl), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one beat, let it be accepted on the next edge, then idle for gap cycles.
  task automatic send_beat(input logic [15:0] s, input logic [15:0] c,
                           input logic ov, input logic last, input int gap);
    check("in_ready_before_beat", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_s = s; in_c = c; in_ovfl = ov; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_ovfl = 1'b0; in_s = '0; in_c = '0;
    for (int i = 0; i < gap; i++) begin
      check("busy_in_gap", 32'(busy), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  // Called #1 after the edge accepting the last beat; waits (bounded) for
  // out_valid, checks latency and result, optionally stays in OUTPUT.
  task automatic wait_result(input string tag, input logic [15:0] exp_sum,
                             input logic exp_ov, input int hold);
    int lat;
    logic [15:0] s0;
    logic o0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
    check({tag, "_ovfl"}, 32'(out_ovfl), 32'(exp_ov));
    check({tag, "_in_ready_out"}, 32'(in_ready), 32'd0);
    check({tag, "_busy_out"}, 32'(busy), 32'd1);
    s0 = out_sum; o0 = out_ovfl;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_sum"}, 32'(out_sum), 32'(exp_sum));
      check({tag, "_hold_ovfl"}, 32'(out_ovfl), 32'(exp_ov));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_busy"}, 32'(busy), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    check({tag, "_sum_retained"}, 32'(out_sum), 32'(s0));
    check({tag, "_ovfl_retained"}, 32'(out_ovfl), 32'(o0));
  endtask

  initial begin
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_ovfl", 32'(out_ovfl), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single beat
    send_beat(16'h1234, 16'h0010, 1'b0, 1'b1, 0);
    wait_result("single", 16'h1244, 1'b0, 0);

    // Three beats with 2-cycle gaps
    send_beat(16'h0100, 16'h0001, 1'b0, 1'b0, 2);
    send_beat(16'h0020, 16'h0002, 1'b0, 1'b0, 2);
    send_beat(16'h0003, 16'h0000, 1'b0, 1'b1, 0);
    wait_result("three", 16'h0126, 1'b0, 0);

    // Overflow from carry, from flag, then cleared
    send_beat(16'hFFFF, 16'h0001, 1'b0, 1'b1, 0);
    wait_result("ovf_carry", 16'h0000, 1'b1, 0);
    send_beat(16'h0000, 16'h0000, 1'b1, 1'b1, 0);
    wait_result("ovf_flag", 16'h0000, 1'b1, 0);
    send_beat(16'h0001, 16'h0000, 1'b0, 1'b1, 0);
    wait_result("ovf_clear", 16'h0001, 1'b0, 0);

    // Overflow lost out of the compressor over two beats
    send_beat(16'h8000, 16'h0000, 1'b0, 1'b0, 0);
    send_beat(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    wait_result("ovf_multi", 16'h0001, 1'b1, 0);

    // Cross-chunk ripple
    send_beat(16'h0FFF, 16'h0001, 1'b0, 1'b1, 0);
    wait_result("ripple1", 16'h1000, 1'b0, 0);
    send_beat(16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 0);
    wait_result("ripple2", 16'hFFFE, 1'b0, 0);

    // Backpressure, then a packet that must exclude prior data
    send_beat(16'hABCD, 16'h0101, 1'b0, 1'b1, 0);
    wait_result("bp", 16'hACCE, 1'b0, 10);
    send_beat(16'h0002, 16'h0001, 1'b0, 1'b1, 0);
    wait_result("after_bp", 16'h0003, 1'b0, 0);

    // Reset after chunk 1 of RESOLVE
    send_beat(16'h1111, 16'h1111, 1'b0, 1'b1, 0);
    @(posedge clk); @(posedge clk); #1;
    check("mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0; #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_sum", 32'(out_sum), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(16'h0005, 16'h0003, 1'b0, 1'b1, 0);
    wait_result("post_rst", 16'h0008, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csa_accum_resolve.md
Name: csa_accum_resolve

Overview:
- Downstream stage of the N-bit 4:2 carry-save adder. Consumes its redundant (sum, carry, overflow) outputs as a packet of beats.
- Folds each beat into a redundant accumulator with an internal 4:2 compression.
- On the last beat, resolves the redundant pair to binary with a chunked, multi-cycle carry-propagate add, then presents the result through a valid/ready handshake.

Parameters:
- WIDTH, 16, datapath width; equals the upstream adder width.
- CHUNK, 4, bits resolved per cycle. WIDTH % CHUNK != 0 is an elaboration error. N = WIDTH/CHUNK.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_s  in  WIDTH  upstream sum vector.
- in_c  in  WIDTH  upstream carry vector, already bit-weighted.
- in_ovfl  in  1  upstream overflow flag.
- in_last  in  1  final beat of packet.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_sum  out  WIDTH  resolved sum, modulo 2^WIDTH.
- out_ovfl  out  1  packet overflow flag.
- busy  out  1  high when state != ACCUM.

Behaviour:
- Clocking/reset: one clock. Reset is asynchronous, active-low (rst_n).
- Reset values: state=ACCUM; acc_s=acc_c=0; ovf=0; chunk index=0; chunk carry=0; out_valid=0; out_sum=0; out_ovfl=0. in_ready is decoded from state, so it is 1 immediately after reset. busy=0.
- States: ACCUM, RESOLVE, OUTPUT.
- ACCUM:
  - in_ready=1.
  - On an accepted beat: {acc_s, acc_c} <= 4:2 compress(acc_s, acc_c, in_s, in_c), so that acc_s + acc_c ≡ previous accumulated value + in_s + in_c (mod 2^WIDTH).
  - Any compression carry at bit WIDTH or above, and in_ovfl, sets ovf. ovf is sticky for the packet.
  - Accepted beat with in_last=1: go to RESOLVE; chunk index=0, chunk carry=0.
  - in_valid low: hold all state; gaps of any length are allowed.
- RESOLVE:
  - in_ready=0.
  - Each cycle k = 0..N-1: bits [k*CHUNK +: CHUNK] of out_sum <= acc_s chunk + acc_c chunk + chunk carry. The chunk carry-out is registered for chunk k+1.
  - On chunk N-1: its carry-out ORs into ovf; out_ovfl <= final ovf; go to OUTPUT.
  - During RESOLVE, out_sum is partially written and not valid.
- OUTPUT:
  - out_valid=1; out_sum and out_ovfl held stable until out_ready. in_ready=0.
  - On handshake: out_valid <= 0; acc_s=acc_c=0; ovf=0; go to ACCUM.
  - out_sum and out_ovfl retain their value until overwritten by the next packet's RESOLVE.
- Latency: out_valid rises exactly N rising edges after the edge that accepts the last beat (4 at defaults). Throughput: one packet per (beats + N + 1) cycles minimum.
- Result definition:
  - out_sum = Σ(in_s + in_c) over the packet, mod 2^WIDTH.
  - out_ovfl = 1 iff any in_ovfl was 1 in the packet or the exact sum ≥ 2^WIDTH.
- Single-beat packets are legal.
- Reset asserted in any state, including mid-RESOLVE or in OUTPUT, returns every register to its reset value and discards the packet.

Test Plan:
- Single beat in_s=0x1234, in_c=0x0010, in_last=1 -> 4 edges later out_valid=1, out_sum=0x1244, out_ovfl=0.
- Three beats (0x0100,0x0001), (0x0020,0x0002), (0x0003,0x0000, last), with 2-cycle in_valid gaps between beats -> out_sum=0x0126, out_ovfl=0.
- Overflow cases:
  - (0xFFFF,0x0001, last) -> out_sum=0x0000, out_ovfl=1.
  - Next packet (0x0000,0x0000, in_ovfl=1, last) -> out_sum=0x0000, out_ovfl=1.
  - Following packet (0x0001,0x0000, last) -> out_ovfl=0, confirming ovf clears.
- Cross-chunk ripple: (0x0FFF,0x0001, last) -> out_sum=0x1000; (0x7FFF,0x7FFF, last) -> 0xFFFE, out_ovfl=0.
- Backpressure: hold out_ready=0 for 10 cycles in OUTPUT -> out_valid, out_sum and out_ovfl stable, in_ready=0, busy=1. Raise out_ready -> next cycle in_ready=1; the next packet's result excludes prior data.
- Reset mid-RESOLVE (after chunk 1): drop rst_n -> immediately out_valid=0, out_sum=0, busy=0, in_ready=1. Release, then send (0x0005,0x0003, last) -> out_sum=0x0008.
